// File: rtl/pll_lock_rst_seq_if.sv
// Bundle between the PLL reset sequencer and its surroundings.
// The bench drives lock/sw_rst_req and observes the rest.
interface pll_lock_rst_seq_if;
    logic       lock;
    logic       sw_rst_req;
    logic       pll_reset;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [7:0] retry_cnt;
    logic [7:0] loss_cnt;

    modport master (
        output lock,
        output sw_rst_req,
        input  pll_reset,
        input  sys_rst,
        input  ready,
        input  state,
        input  retry_cnt,
        input  loss_cnt
    );

    modport slave (
        input  lock,
        input  sw_rst_req,
        output pll_reset,
        output sys_rst,
        output ready,
        output state,
        output retry_cnt,
        output loss_cnt
    );
endinterface

// File: rtl/pll_lock_rst_seq.sv
// PLL bring-up sequencer: pulses PLL reset, waits for a stable
// synchronized lock, then releases the downstream system reset.
module pll_lock_rst_seq #(
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int STABLE_CYC   = 1024,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clkin,
    input  logic                 reset,
    pll_lock_rst_seq_if.slave    bus
);

    localparam int PW = $clog2(PLL_RST_CYC + 1);
    localparam int TW = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW = $clog2(STABLE_CYC + 1);

    localparam logic [PW-1:0] P_LAST = PW'(PLL_RST_CYC - 1);
    localparam logic [TW-1:0] T_LAST = TW'(LOCK_TIMEOUT - 1);
    localparam logic [SW-1:0] S_LAST = SW'(STABLE_CYC - 1);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [PW-1:0]          pcnt_q, pcnt_d;
    logic [TW-1:0]          tcnt_q, tcnt_d;
    logic [SW-1:0]          scnt_q, scnt_d;
    logic [7:0]             retry_q, retry_d;
    logic [7:0]             loss_q, loss_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lock_s;
    logic                   pll_reset_q;
    logic                   sys_rst_q;
    logic                   ready_q;

    assign lock_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clkin) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.lock};
        end
    end

    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        tcnt_d  = tcnt_q;
        scnt_d  = scnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        // A loss in RUN is counted even when a software restart wins.
        if (state_q == RUN && !lock_s && loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
        end

        if (bus.sw_rst_req) begin
            state_d = PLL_RST;
            pcnt_d  = '0;
            tcnt_d  = '0;
            scnt_d  = '0;
        end else begin
            unique case (state_q)
                PLL_RST: begin
                    if (pcnt_q == P_LAST) begin
                        state_d = WAIT_LOCK;
                        pcnt_d  = '0;
                        tcnt_d  = '0;
                    end else begin
                        pcnt_d = pcnt_q + PW'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d = STABLE;
                        scnt_d  = '0;
                    end else if (tcnt_q == T_LAST) begin
                        state_d = PLL_RST;
                        pcnt_d  = '0;
                        tcnt_d  = '0;
                        if (retry_q != 8'hFF) begin
                            retry_d = retry_q + 8'd1;
                        end
                    end else begin
                        tcnt_d = tcnt_q + TW'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        tcnt_d  = '0;
                    end else if (scnt_q == S_LAST) begin
                        state_d = RUN;
                        scnt_d  = '0;
                    end else begin
                        scnt_d = scnt_q + SW'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_d = PLL_RST;
                        pcnt_d  = '0;
                    end
                end
                default: begin
                    state_d = PLL_RST;
                    pcnt_d  = '0;
                end
            endcase
        end
    end

    // Outputs are flopped from the next state so they align with state_q.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= PLL_RST;
            pcnt_q      <= '0;
            tcnt_q      <= '0;
            scnt_q      <= '0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_reset_q <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcnt_q      <= pcnt_d;
            tcnt_q      <= tcnt_d;
            scnt_q      <= scnt_d;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_reset_q <= (state_d == PLL_RST);
            sys_rst_q   <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign bus.state     = state_q;
    assign bus.pll_reset = pll_reset_q;
    assign bus.sys_rst   = sys_rst_q;
    assign bus.ready     = ready_q;
    assign bus.retry_cnt = retry_q;
    assign bus.loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Directed and randomized bench for pll_lock_rst_seq with a
// cycle-level reference model built from dwell times and a lock delay line.
module tb_pll_lock_rst_seq;

    localparam int PRC = 4;
    localparam int LT  = 20;
    localparam int SC  = 8;
    localparam int SS  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pll_lock_rst_seq_if bus();

    pll_lock_rst_seq #(
        .PLL_RST_CYC  (PRC),
        .LOCK_TIMEOUT (LT),
        .STABLE_CYC   (SC),
        .SYNC_STAGES  (SS)
    ) dut (
        .clkin (clk),
        .reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: state id, cycles spent in it, event counters, lock delay line.
    int m_state;
    int m_dwell;
    int m_retry;
    int m_loss;
    bit mq[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_state = 0;
        m_dwell = 0;
        m_retry = 0;
        m_loss  = 0;
        mq.delete();
        repeat (SS) mq.push_back(1'b0);
    endtask

    task automatic m_step();
        bit ls;
        if (rst) begin
            m_clear();
        end else begin
            ls = mq.pop_front();
            mq.push_back(bus.lock);
            if (m_state == 3 && !ls && m_loss < 255) m_loss++;
            if (bus.sw_rst_req) begin
                m_state = 0;
                m_dwell = 0;
            end else begin
                case (m_state)
                    0: begin
                        m_dwell++;
                        if (m_dwell == PRC) begin
                            m_state = 1;
                            m_dwell = 0;
                        end
                    end
                    1: begin
                        if (ls) begin
                            m_state = 2;
                            m_dwell = 0;
                        end else begin
                            m_dwell++;
                            if (m_dwell == LT) begin
                                m_state = 0;
                                m_dwell = 0;
                                if (m_retry < 255) m_retry++;
                            end
                        end
                    end
                    2: begin
                        if (!ls) begin
                            m_state = 1;
                            m_dwell = 0;
                        end else begin
                            m_dwell++;
                            if (m_dwell == SC) begin
                                m_state = 3;
                                m_dwell = 0;
                            end
                        end
                    end
                    default: begin
                        if (!ls) begin
                            m_state = 0;
                            m_dwell = 0;
                        end
                    end
                endcase
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        chk("m_state", bus.state, m_state);
        chk("m_pll_reset", bus.pll_reset, (m_state == 0));
        chk("m_sys_rst", bus.sys_rst, (m_state != 3));
        chk("m_ready", bus.ready, (m_state == 3));
        chk("m_retry", bus.retry_cnt, m_retry);
        chk("m_loss", bus.loss_cnt, m_loss);
    endtask

    task automatic wait_state(input int s, input int max, input string tag);
        int n;
        n = 0;
        while (int'(bus.state) != s && n < max) begin
            tick();
            n++;
        end
        chk(tag, bus.state, s);
    endtask

    initial begin
        int n;
        int pr;
        int srlow;
        int prev;
        int run_left;
        logic lv;

        bus.lock = 1'b0;
        bus.sw_rst_req = 1'b0;
        rst = 1'b1;
        m_clear();
        @(negedge clk);

        repeat (3) tick();
        chk("rst_state", bus.state, 0);
        chk("rst_pll_reset", bus.pll_reset, 1);
        chk("rst_sys_rst", bus.sys_rst, 1);
        chk("rst_ready", bus.ready, 0);
        chk("rst_retry", bus.retry_cnt, 0);
        chk("rst_loss", bus.loss_cnt, 0);

        // Normal bring-up
        rst = 1'b0;
        n = bus.pll_reset ? 1 : 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.pll_reset) n++;
        end
        chk("bringup_pulse_len", n, 4);
        bus.lock = 1'b1;
        n = 0;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
        chk("bringup_lock_to_ready", n, 11);
        chk("bringup_retry", bus.retry_cnt, 0);

        // Loss in RUN
        repeat (5) tick();
        bus.lock = 1'b0;
        tick();
        tick();
        chk("loss_still_run", bus.state, 3);
        tick();
        chk("loss_state", bus.state, 0);
        chk("loss_sys_rst", bus.sys_rst, 1);
        chk("loss_cnt_one", bus.loss_cnt, 1);
        bus.lock = 1'b1;
        wait_state(3, 60, "loss_reacquire");

        // Glitchy lock
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.lock = 1'b0;
        repeat (10) tick();
        bus.lock = 1'b1;
        n = 0;
        repeat (5) begin
            tick();
            n++;
        end
        bus.lock = 1'b0;
        tick();
        n++;
        bus.lock = 1'b1;
        while (!bus.ready && n < 100) begin
            tick();
            n++;
        end
        chk("glitch_lock_to_ready", n, 17);
        chk("glitch_retry", bus.retry_cnt, 0);

        // No lock: repeated timeouts
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.lock = 1'b0;
        pr = bus.pll_reset ? 1 : 0;
        srlow = 0;
        for (int t = 1; t <= 72; t++) begin
            tick();
            if (bus.pll_reset) pr++;
            if (!bus.sys_rst) srlow++;
            if (t == 23) chk("nolock_retry0", bus.retry_cnt, 0);
            if (t == 24) chk("nolock_retry1", bus.retry_cnt, 1);
            if (t == 48) chk("nolock_retry2", bus.retry_cnt, 2);
            if (t == 72) chk("nolock_retry3", bus.retry_cnt, 3);
        end
        chk("nolock_pll_cycles", pr, 13);
        chk("nolock_sys_rst_low", srlow, 0);

        // Software restart coinciding with lock loss in RUN
        bus.lock = 1'b1;
        wait_state(3, 60, "sw_reach_run");
        prev = int'(bus.loss_cnt);
        bus.lock = 1'b0;
        tick();
        tick();
        bus.sw_rst_req = 1'b1;
        tick();
        bus.sw_rst_req = 1'b0;
        chk("sw_state", bus.state, 0);
        chk("sw_loss_inc", bus.loss_cnt, prev + 1);
        bus.lock = 1'b1;
        tick();
        chk("sw_loss_once", bus.loss_cnt, prev + 1);

        // Forced losses until saturation
        repeat (300) begin
            bus.lock = 1'b1;
            wait_state(3, 60, "sat_reach_run");
            bus.lock = 1'b0;
            repeat (3) tick();
        end
        chk("sat_loss", bus.loss_cnt, 255);
        chk("sat_retry", bus.retry_cnt, 3);

        // Reset mid-STABLE
        bus.lock = 1'b1;
        wait_state(2, 60, "mid_reach_stable");
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_state", bus.state, 0);
        chk("mid_pll_reset", bus.pll_reset, 1);
        chk("mid_sys_rst", bus.sys_rst, 1);
        chk("mid_ready", bus.ready, 0);
        chk("mid_retry", bus.retry_cnt, 0);
        chk("mid_loss", bus.loss_cnt, 0);

        // Randomized lock behaviour, restarts and resets
        rst = 1'b0;
        lv = 1'b0;
        run_left = 0;
        repeat (4000) begin
            if (run_left == 0) begin
                lv = ~lv;
                run_left = lv ? int'($urandom_range(1, 40))
                              : int'($urandom_range(1, 30));
            end
            bus.lock = lv;
            bus.sw_rst_req = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
            run_left--;
        end
        bus.sw_rst_req = 1'b0;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
